mem_access_unit: RTL and testbench

Load/store sequencer that sits directly upstream of the 256x16 synchronous data memory. It accepts single-word store requests and 1-4 word load bursts from the execute stage over a valid/ready handshake. It drives the memory's address, write-data, read-enable and write-enable pins. Load data returns to writeback over a valid/ready response channel, and the unit can sustain one word per cycle when the consumer holds ready high.

---
 rtl/mem_access_unit.sv | 110 +++++++++++
 tb/tb_mem_access_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of a 256x16 synchronous data memory.
// Single-word stores, 1-4 word load bursts, one response word per cycle when the consumer keeps ready high.
module mem_access_unit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [LEN_W-1:0]  req_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              wr_done,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, WR, RD_ISSUE, RD_RESP} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [LEN_W-1:0]  rem_q;
  logic              accept;
  logic              advance;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rem_q   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        rem_q   <= req_len;
      end else if (advance) begin
        addr_q <= addr_q + 1'b1;
        rem_q  <= rem_q - 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    advance   = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_last  = 1'b0;
    rsp_data  = mem_rdata;
    wr_done   = 1'b0;
    busy      = (state != IDLE);
    mem_addr  = '0;
    mem_wdata = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = req_we ? WR : RD_ISSUE;
        end
      end
      WR: begin
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        wr_done   = 1'b1;
        state_nxt = IDLE;
      end
      RD_ISSUE: begin
        mem_re    = 1'b1;
        mem_addr  = addr_q;
        state_nxt = RD_RESP;
      end
      RD_RESP: begin
        rsp_valid = 1'b1;
        rsp_last  = (rem_q == '0);
        mem_addr  = addr_q;
        if (rsp_ready) begin
          if (rem_q == '0) begin
            state_nxt = IDLE;
          end else begin
            // Issue the next read in the handshake cycle so words stream back-to-back.
            advance  = 1'b1;
            mem_re   = 1'b1;
            mem_addr = addr_q + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit with a behavioural 256x16 synchronous memory and a load-response scoreboard.
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_len;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_last;
  logic        wr_done;
  logic        busy;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_re;
  logic        mem_we;
  logic [15:0] mem_rdata;

  logic [15:0] mem [256];
  logic [15:0] exp_mem [256];
  logic [16:0] exp_q [$];
  logic [7:0]  exp_addr_q [$];
  int          n_cmp;
  int          n_bad;

  mem_access_unit #(.ADDR_W(8), .DATA_W(16), .LEN_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .wr_done(wr_done), .busy(busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_last, wr_done, busy, mem_re, mem_we} !== 7'b1000000) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b expected %b",
               {req_ready, rsp_valid, rsp_last, wr_done, busy, mem_re, mem_we}, 7'b1000000);
    end
    n_cmp++;
    if ({mem_addr, mem_wdata} !== 24'h0) begin
      n_bad++;
      $display("FAIL reset_mem_bus: got %h expected 000000", {mem_addr, mem_wdata});
    end
    n_cmp++;
    if (rsp_data !== 16'hA5A5) begin
      n_bad++;
      $display("FAIL reset_rsp_data: got %h expected a5a5", rsp_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_store(input logic [7:0] addr, input logic [15:0] data, input string name);
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_ready: got %b expected 1", name, req_ready);
    end
    req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_wdata = data; req_len = 2'd0;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    n_cmp++;
    if ({mem_we, mem_re, wr_done, busy, req_ready, mem_addr, mem_wdata} !== {5'b10110, addr, data}) begin
      n_bad++;
      $display("FAIL %s_write: got %h expected %h", name,
               {mem_we, mem_re, wr_done, busy, req_ready, mem_addr, mem_wdata}, {5'b10110, addr, data});
    end
    exp_mem[addr] = data;
    @(negedge clk);
    #1;
    n_cmp++;
    if ({mem_we, wr_done, busy, req_ready} !== 4'b0001) begin
      n_bad++;
      $display("FAIL %s_done: got %b expected 0001", name, {mem_we, wr_done, busy, req_ready});
    end
  endtask

  // pat bit k is rsp_ready for the k-th cycle of the response phase (wraps after pat_n).
  task automatic do_load(input logic [7:0] addr, input logic [1:0] len, input logic [6:0] pat,
                         input int pat_n, input string name);
    logic [7:0]  a;
    logic [16:0] e;
    int          k;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_ready: got %b expected 1", name, req_ready);
    end
    req_valid = 1'b1; req_we = 1'b0; req_addr = addr; req_len = len;
    for (int i = 0; i <= int'(len); i++) begin
      a = addr + 8'(i);
      exp_q.push_back({(i == int'(len)), exp_mem[a]});
      exp_addr_q.push_back(a);
    end
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    a = exp_addr_q.pop_front();
    n_cmp++;
    if ({mem_re, mem_we, rsp_valid, busy, mem_addr} !== {4'b1001, a}) begin
      n_bad++;
      $display("FAIL %s_issue: got %h expected %h", name, {mem_re, mem_we, rsp_valid, busy, mem_addr}, {4'b1001, a});
    end
    k = 0;
    while (exp_q.size() > 0 && k < 40) begin
      @(negedge clk);
      rsp_ready = pat[k % pat_n];
      #1;
      n_cmp++;
      if (rsp_valid !== 1'b1 || mem_we !== 1'b0) begin
        n_bad++;
        $display("FAIL %s_valid cycle %0d: got valid=%b we=%b expected valid=1 we=0", name, k, rsp_valid, mem_we);
      end else if (rsp_ready) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ({rsp_last, rsp_data} !== e) begin
          n_bad++;
          $display("FAIL %s_word cycle %0d: got last=%b data=%h expected last=%b data=%h",
                   name, k, rsp_last, rsp_data, e[16], e[15:0]);
        end
        n_cmp++;
        if (exp_q.size() > 0) begin
          a = exp_addr_q.pop_front();
          if ({mem_re, mem_addr} !== {1'b1, a}) begin
            n_bad++;
            $display("FAIL %s_next_read: got re=%b addr=%h expected re=1 addr=%h", name, mem_re, mem_addr, a);
          end
        end else if (mem_re !== 1'b0) begin
          n_bad++;
          $display("FAIL %s_final_re: got %b expected 0", name, mem_re);
        end
      end else begin
        n_cmp++;
        if ({mem_re, rsp_last, rsp_data} !== {1'b0, exp_q[0]}) begin
          n_bad++;
          $display("FAIL %s_hold cycle %0d: got re=%b last=%b data=%h expected re=0 last=%b data=%h",
                   name, k, mem_re, rsp_last, rsp_data, exp_q[0][16], exp_q[0][15:0]);
        end
      end
      k++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got %0d words left expected 0", name, exp_q.size());
      exp_q.delete();
      exp_addr_q.delete();
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    n_cmp++;
    if ({busy, req_ready, rsp_valid, mem_re} !== 4'b0100) begin
      n_bad++;
      $display("FAIL %s_idle: got %b expected 0100", name, {busy, req_ready, rsp_valid, mem_re});
    end
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h30; req_len = 2'd3;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    n_cmp++;
    if ({rsp_valid, rsp_data} !== {1'b1, exp_mem[8'h30]}) begin
      n_bad++;
      $display("FAIL rst_burst_beat1: got %b %h expected 1 %h", rsp_valid, rsp_data, exp_mem[8'h30]);
    end
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_last, busy, mem_re, mem_we, mem_addr} !== {6'b100000, 8'h00}) begin
      n_bad++;
      $display("FAIL rst_burst_outputs: got %h expected %h",
               {req_ready, rsp_valid, rsp_last, busy, mem_re, mem_we, mem_addr}, {6'b100000, 8'h00});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if ({mem_re, mem_we, rsp_valid} !== 3'b000) begin
        n_bad++;
        $display("FAIL rst_burst_quiet cycle %0d: got %b expected 000", i, {mem_re, mem_we, rsp_valid});
      end
    end
    rsp_ready = 1'b0;
    rst_n = 1'b1;
    do_load(8'h22, 2'd0, 7'h7F, 1, "after_rst");
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_len = '0;
    rsp_ready = 1'b0;
    mem_rdata = 16'hA5A5;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'(i * 16'h0101 + 16'h7000);
      exp_mem[i] = mem[i];
    end
    for (int i = 0; i < 4; i++) begin
      mem[8'h20 + i] = 16'(i + 1);
      exp_mem[8'h20 + i] = 16'(i + 1);
    end
    mem[8'hFE] = 16'hC0FE; exp_mem[8'hFE] = 16'hC0FE;
    mem[8'hFF] = 16'hC0FF; exp_mem[8'hFF] = 16'hC0FF;
    mem[8'h00] = 16'hC000; exp_mem[8'h00] = 16'hC000;
    mem[8'h01] = 16'hC001; exp_mem[8'h01] = 16'hC001;

    test_reset();
    do_store(8'h10, 16'hBEEF, "store_beef");
    do_load(8'h20, 2'd3, 7'h7F, 1, "burst_ready");
    do_load(8'h20, 2'd3, 7'b1011001, 7, "burst_toggle");
    do_load(8'hFE, 2'd3, 7'h7F, 1, "burst_wrap");
    do_store(8'h05, 16'h1234, "store_1234");
    do_load(8'h05, 2'd0, 7'h7F, 1, "load_1234");
    do_load(8'h10, 2'd1, 7'b0000110, 3, "load_beef");
    test_reset_mid_burst();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
